fir_xifu_ctrl: RTL and testbench

- In-order scoreboard/controller for the FIR XIFU pipeline.
- Records every instruction the decode stage issues and tracks the XIF commit/kill for each one.
- Gates the writeback stage so XIFU register-file writes happen only for committed instructions; stalls the pipe when a result reaches writeback before its commit.
- Back-pressures issue when the scoreboard is full.

---
 rtl/fir_xifu_pkg.sv | 30 +++
 rtl/fir_xifu_ctrl_perf.sv | 28 ++
 rtl/fir_xifu_ctrl.sv | 144 ++++++++++++++
 tb/tb_fir_xifu_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIFU controller: scoreboard entry state, entry layout, perf counter bank shape.
package fir_xifu_pkg;

  localparam int XIF_ID_W    = 4;
  localparam int NB_PERF_CNT = 4;
  localparam int PERF_CNT_W  = 32;

  localparam int PERF_ISSUE = 0;
  localparam int PERF_WRITE = 1;
  localparam int PERF_DROP  = 2;
  localparam int PERF_STALL = 3;

  typedef enum logic [1:0] {
    SB_FREE      = 2'd0,
    SB_ISSUED    = 2'd1,
    SB_COMMITTED = 2'd2,
    SB_KILLED    = 2'd3
  } sb_state_e;

  typedef struct packed {
    sb_state_e             state;
    logic [XIF_ID_W-1:0]   id;
  } sb_entry_t;

  typedef struct packed {
    logic                  valid;
    logic [XIF_ID_W-1:0]   id;
  } id2ctrl_t;

endpackage

// File: rtl/fir_xifu_ctrl_perf.sv
// Saturating event counter bank for the XIFU controller; cleared only by reset.
module fir_xifu_ctrl_perf
  import fir_xifu_pkg::*;
(
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NB_PERF_CNT-1:0]              inc_i,
  output logic [NB_PERF_CNT*PERF_CNT_W-1:0]   perf_o
);

  logic [PERF_CNT_W-1:0] r_cnt [NB_PERF_CNT];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NB_PERF_CNT; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB_PERF_CNT; i++) begin
        if (inc_i[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    perf_o = '0;
    for (int i = 0; i < NB_PERF_CNT; i++) perf_o[i*PERF_CNT_W +: PERF_CNT_W] = r_cnt[i];
  end

endmodule

// File: rtl/fir_xifu_ctrl.sv
// In-order issue/commit/writeback scoreboard for the FIR XIFU pipeline.
// Build option: define FIR_XIFU_CTRL_PERF_EN to instantiate the perf counter bank on perf_o.
module fir_xifu_ctrl
  import fir_xifu_pkg::*;
#(
  parameter int NB_ENTRIES = 4,
  parameter int ID_WIDTH   = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               clear_i,
  input  logic                               issue_valid_i,
  input  logic [ID_WIDTH-1:0]                issue_id_i,
  input  logic                               commit_valid_i,
  input  logic [ID_WIDTH-1:0]                commit_id_i,
  input  logic                               commit_kill_i,
  input  logic                               wb_req_i,
  input  logic [ID_WIDTH-1:0]                wb_id_i,
  output logic                               ready_o,
  output logic                               wb_we_o,
  output logic                               wb_drop_o,
  output logic                               busy_o,
  output logic                               err_o,
  output logic [NB_PERF_CNT*PERF_CNT_W-1:0]  perf_o
);

  localparam int PTR_W = $clog2(NB_ENTRIES);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NB_ENTRIES);

  typedef struct packed {
    sb_state_e           state;
    logic [ID_WIDTH-1:0] id;
  } entry_t;

  entry_t           r_ent [NB_ENTRIES];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_busy, r_err;

  logic             w_cmt_hit, w_cmt_act, w_cmt_ok, w_cmt_err;
  logic [PTR_W-1:0] w_cmt_idx, w_scan;
  sb_state_e        w_cmt_state, w_head_state;
  logic             w_empty, w_full, w_wb_act, w_wb_ok, w_wb_err;
  logic             w_stall, w_fire, w_retire;
  logic [CNT_W-1:0] w_count_nxt;

  // Oldest matching live entry wins, so duplicate ids resolve in program order.
  always_comb begin
    w_cmt_hit = 1'b0;
    w_cmt_idx = '0;
    w_scan    = r_head;
    for (int k = 0; k < NB_ENTRIES; k++) begin
      if (!w_cmt_hit && (r_ent[w_scan].state != SB_FREE) && (r_ent[w_scan].id == commit_id_i)) begin
        w_cmt_hit = 1'b1;
        w_cmt_idx = w_scan;
      end
      w_scan = w_scan + 1'b1;
    end
  end

  assign w_cmt_act   = commit_valid_i & ~clear_i;
  assign w_cmt_ok    = w_cmt_act & w_cmt_hit & (r_ent[w_cmt_idx].state == SB_ISSUED);
  assign w_cmt_err   = w_cmt_act & ~w_cmt_ok;
  assign w_cmt_state = commit_kill_i ? SB_KILLED : SB_COMMITTED;

  // Same-cycle commit to the head is seen by writeback as already applied.
  assign w_head_state = (w_cmt_ok && (w_cmt_idx == r_head)) ? w_cmt_state : r_ent[r_head].state;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);
  assign w_wb_act = wb_req_i & ~clear_i;
  assign w_wb_ok  = w_wb_act & ~w_empty & (wb_id_i == r_ent[r_head].id);
  assign w_wb_err = w_wb_act & ~w_wb_ok;

  assign wb_we_o   = w_wb_ok & (w_head_state == SB_COMMITTED);
  assign wb_drop_o = w_wb_ok & (w_head_state == SB_KILLED);
  assign w_stall   = w_wb_ok & (w_head_state == SB_ISSUED);
  assign w_retire  = wb_we_o | wb_drop_o;

  // Handshake: an issue is accepted on a cycle where issue_valid_i and ready_o are both high;
  // ready_o never looks at issue_valid_i, and a retire frees its slot only from the next cycle.
  assign ready_o = ~w_full & ~w_stall;
  assign w_fire  = issue_valid_i & ready_o & ~clear_i;

  assign w_count_nxt = r_count + {{PTR_W{1'b0}}, w_fire} - {{PTR_W{1'b0}}, w_retire};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NB_ENTRIES; i++) r_ent[i] <= '{state: SB_FREE, id: '0};
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_cmt_err | w_wb_err) r_err <= 1'b1;
      if (clear_i) begin
        for (int i = 0; i < NB_ENTRIES; i++) r_ent[i].state <= SB_FREE;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_busy  <= 1'b0;
      end else begin
        if (w_cmt_ok) r_ent[w_cmt_idx].state <= w_cmt_state;
        if (w_retire) begin
          r_ent[r_head].state <= SB_FREE;
          r_head              <= r_head + 1'b1;
        end
        if (w_fire) begin
          r_ent[r_tail] <= '{state: SB_ISSUED, id: issue_id_i};
          r_tail        <= r_tail + 1'b1;
        end
        r_count <= w_count_nxt;
        r_busy  <= (w_count_nxt != '0);
      end
    end
  end

  assign busy_o = r_busy;
  assign err_o  = r_err;

`ifdef FIR_XIFU_CTRL_PERF_EN
  logic [NB_PERF_CNT-1:0] w_perf_inc;

  always_comb begin
    w_perf_inc             = '0;
    w_perf_inc[PERF_ISSUE] = w_fire;
    w_perf_inc[PERF_WRITE] = wb_we_o;
    w_perf_inc[PERF_DROP]  = wb_drop_o;
    w_perf_inc[PERF_STALL] = w_stall;
  end

  fir_xifu_ctrl_perf u_perf (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (w_perf_inc),
    .perf_o (perf_o)
  );
`else
  assign perf_o = '0;
`endif

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// Self-checking bench for fir_xifu_ctrl: directed scenarios then random traffic against a queue model.
module tb_fir_xifu_ctrl;

  localparam int NB  = 4;
  localparam int IDW = 4;
  localparam int ST_ISS  = 0;
  localparam int ST_CMT  = 1;
  localparam int ST_KILL = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           clear;
  logic           issue_valid;
  logic [IDW-1:0] issue_id;
  logic           commit_valid;
  logic [IDW-1:0] commit_id;
  logic           commit_kill;
  logic           wb_req;
  logic [IDW-1:0] wb_id;
  logic           ready_o, wb_we_o, wb_drop_o, busy_o, err_o;
  logic [127:0]   perf_o;

  fir_xifu_ctrl #(.NB_ENTRIES(NB), .ID_WIDTH(IDW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clear_i        (clear),
    .issue_valid_i  (issue_valid),
    .issue_id_i     (issue_id),
    .commit_valid_i (commit_valid),
    .commit_id_i    (commit_id),
    .commit_kill_i  (commit_kill),
    .wb_req_i       (wb_req),
    .wb_id_i        (wb_id),
    .ready_o        (ready_o),
    .wb_we_o        (wb_we_o),
    .wb_drop_o      (wb_drop_o),
    .busy_o         (busy_o),
    .err_o          (err_o),
    .perf_o         (perf_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: in-flight instructions oldest first
  logic [IDW-1:0] exp_q[$];
  int             st_q[$];
  logic           m_err;
  int unsigned    m_perf[4];
  int             n_checks = 0;
  int             n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    st_q.delete();
    m_err = 1'b0;
    for (int i = 0; i < 4; i++) m_perf[i] = 0;
  endtask

  task automatic model_check();
    logic e_we, e_drop, e_stall, e_ready, new_err, fire;
    int   n, hit;
    e_we = 0; e_drop = 0; e_stall = 0; new_err = 0; fire = 0;
    n = exp_q.size();
    check_eq("busy", busy_o, n != 0);
    check_eq("err", err_o, m_err);
`ifdef FIR_XIFU_CTRL_PERF_EN
    check_eq("perf", perf_o, {m_perf[3], m_perf[2], m_perf[1], m_perf[0]});
`else
    check_eq("perf_off", perf_o, 128'd0);
`endif
    if (clear) begin
      e_ready = (n < NB);
    end else begin
      if (commit_valid) begin
        hit = -1;
        for (int i = 0; i < n; i++) if (hit < 0 && exp_q[i] == commit_id) hit = i;
        if (hit >= 0 && st_q[hit] == ST_ISS) st_q[hit] = commit_kill ? ST_KILL : ST_CMT;
        else new_err = 1;
      end
      if (wb_req) begin
        if (n == 0 || exp_q[0] != wb_id) new_err = 1;
        else if (st_q[0] == ST_CMT)       e_we    = 1;
        else if (st_q[0] == ST_KILL)      e_drop  = 1;
        else                              e_stall = 1;
      end
      e_ready = (n < NB) && !e_stall;
      fire    = issue_valid && e_ready;
    end
    check_eq("wb_we", wb_we_o, e_we);
    check_eq("wb_drop", wb_drop_o, e_drop);
    check_eq("ready", ready_o, e_ready);
    if (clear) begin
      exp_q.delete();
      st_q.delete();
    end else begin
      if (e_we || e_drop) begin
        void'(exp_q.pop_front());
        void'(st_q.pop_front());
      end
      if (fire) begin
        exp_q.push_back(issue_id);
        st_q.push_back(ST_ISS);
      end
    end
    if (new_err) m_err = 1'b1;
    if (fire)    m_perf[0]++;
    if (e_we)    m_perf[1]++;
    if (e_drop)  m_perf[2]++;
    if (e_stall) m_perf[3]++;
  endtask

  // driver tasks
  task automatic cycle(input logic iv, input logic [IDW-1:0] iid,
                       input logic cv, input logic [IDW-1:0] cid, input logic ck,
                       input logic wr, input logic [IDW-1:0] wid, input logic clr);
    issue_valid = iv; issue_id = iid;
    commit_valid = cv; commit_id = cid; commit_kill = ck;
    wb_req = wr; wb_id = wid; clear = clr;
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, ready_o, 1'b1);
    check_eq({tag, "_we"}, wb_we_o, 1'b0);
    check_eq({tag, "_drop"}, wb_drop_o, 1'b0);
    check_eq({tag, "_busy"}, busy_o, 1'b0);
    check_eq({tag, "_err"}, err_o, 1'b0);
    check_eq({tag, "_perf"}, perf_o, 128'd0);
  endtask

  initial begin
    logic           r_iv, r_cv, r_ck, r_wr, r_clr;
    logic [IDW-1:0] r_iid, r_cid, r_wid;
    rst = 1'b1; clear = 0; issue_valid = 0; issue_id = 0;
    commit_valid = 0; commit_id = 0; commit_kill = 0; wb_req = 0; wb_id = 0;
    model_reset();
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // basic flow
    cycle(1, 3, 0, 0, 0, 0, 0, 0);
    idle();
    cycle(0, 0, 1, 3, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 3, 0);
    idle();
    idle();

    // kill
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 2, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 2, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 2, 0);
    idle();

    // stall then same-cycle commit bypass
    cycle(1, 5, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1, 5, 0);
    cycle(0, 0, 1, 5, 0, 1, 5, 0);
    idle();

    // full and wrap
    for (int i = 0; i < 4; i++) cycle(1, IDW'(i), 0, 0, 0, 0, 0, 0);
    cycle(1, 4, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    cycle(1, 4, 0, 0, 0, 1, 0, 0);
    cycle(1, 4, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cycle(0, 0, 1, IDW'(i), 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cycle(0, 0, 0, 0, 0, 1, IDW'(i), 0);
    idle();

    // protocol errors
    cycle(0, 0, 1, 9, 0, 0, 0, 0);
    idle();
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 2, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 2, 0, 1, 2, 0);
    cycle(0, 0, 1, 1, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 2, 0);
    idle();

    // flush with everything else asserted in the same cycle
    cycle(1, 6, 0, 0, 0, 0, 0, 0);
    cycle(1, 7, 0, 0, 0, 0, 0, 0);
    cycle(1, 8, 0, 0, 0, 0, 0, 0);
    cycle(1, 9, 1, 6, 0, 1, 6, 1);
    idle();
    idle();

    // asynchronous reset in the middle of a stall
    cycle(1, 5, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 5, 0);
    issue_valid = 0; commit_valid = 0; clear = 0;
    wb_req = 1; wb_id = 5;
    @(negedge clk);
    model_check();
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("async_rst");
    wb_req = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      r_iv  = 1'($urandom_range(0, 1));
      r_iid = IDW'($urandom_range(0, 15));
      r_cv  = ($urandom_range(0, 2) == 0);
      if (exp_q.size() > 0 && $urandom_range(0, 7) != 0)
        r_cid = exp_q[$urandom_range(0, exp_q.size() - 1)];
      else
        r_cid = IDW'($urandom_range(0, 15));
      r_ck  = ($urandom_range(0, 3) == 0);
      r_wr  = ($urandom_range(0, 2) != 0);
      if (exp_q.size() > 0 && $urandom_range(0, 9) != 0) r_wid = exp_q[0];
      else                                               r_wid = IDW'($urandom_range(0, 15));
      r_clr = ($urandom_range(0, 49) == 0);
      cycle(r_iv, r_iid, r_cv, r_cid, r_ck, r_wr, r_wid, r_clr);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
